pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and bubble insertion.
- Payload is an opaque DW-bit bus: the concatenation of the decode-to-execute fields (inst, inst_addr, op1, op2, rd_addr, reg_wen, base_addr, offset_addr) or any other stage's fields.
- Replaces the fixed hold-only stage registers between IF/ID/EX.
- Optional 2-entry skid mode makes in_ready_o a pure register output, which breaks the back-pressure timing path.

Parameters:
- DW, 32: payload width in bits, >= 1.
- NOP_VAL, {DW{1'b0}}: payload driven whenever the stage holds no valid entry (bubble); the integrator places INST_NOP in the inst field.
- SKID, 0: 0 = single register, combinational in_ready_o. 1 = main + skid register, registered in_ready_o.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- flush_i, input, 1: synchronous kill of all held entries (branch/jump redirect from ctrl).
- in_valid_i, input, 1: upstream entry is valid.
- in_ready_o, output, 1: stage can accept this cycle.
- in_data_i, input, DW: upstream payload.
- out_valid_o, output, 1: out_data_o holds a valid entry.
- out_ready_i, input, 1: downstream consumes this cycle.
- out_data_o, output, DW: head payload; equals NOP_VAL when out_valid_o = 0.
- count_o, output, 2: entries held (0..1 when SKID=0, 0..2 when SKID=1).

Behaviour:
- Accept = in_valid_i & in_ready_o. Consume = out_valid_o & out_ready_i. All state updates on the rising clk edge.
- Reset, while rst=1 and on the edge:
  - out_valid_o=0, out_data_o=NOP_VAL, count_o=0, skid slot empty.
  - in_ready_o=0 for the whole reset cycle.
  - in_ready_o=1 from the first cycle after rst deasserts.
  - Reset mid-transfer discards all entries, with no consume.
- Latency: 1 cycle. An entry accepted at edge N appears on out_data_o with out_valid_o=1 after edge N.
- Ordering: strict FIFO, with no duplication or loss except by flush/rst.
- SKID=0:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational, gated by ~rst).
  - Accept loads the register; out_valid_o <= 1.
  - Consume without accept: out_valid_o <= 0, out_data_o <= NOP_VAL.
  - Consume and accept in the same cycle: the new entry replaces the old, giving full throughput.
  - No accept, no consume: hold.
- SKID=1, states EMPTY(0), ONE(1), TWO(2) = count_o:
  - in_ready_o = (state != TWO), registered; no combinational path from out_ready_i.
  - EMPTY: accept -> ONE.
  - ONE, accept & ~consume: entry goes to skid -> TWO.
  - ONE, accept & consume: main <= in_data_i, stay ONE.
  - ONE, consume only -> EMPTY.
  - TWO, consume: main <= skid -> ONE. No accept is possible in TWO.
  - Throughput is 1 entry/cycle when out_ready_i stays high.
- Flush:
  - flush_i=1 at edge: all entries dropped, out_valid_o <= 0, out_data_o <= NOP_VAL, count_o <= 0.
  - An input accepted in the same cycle is discarded; flush has priority over accept and over hold.
  - Downstream may still see a consume in that cycle (head valid pre-edge). This is legal; the head counts as delivered.
  - in_ready_o is not gated by flush_i.
- Priority: rst > flush_i > accept/consume.
- Invariants:
  - count_o never exceeds 1 (SKID=0) or 2 (SKID=1).
  - out_data_o == NOP_VAL whenever out_valid_o == 0.
  - in_data_i is ignored when not accepted.
- Both modes must be synthesizable from one source via generate on SKID. No latches.

Decomposition:
- Shared package/defines:
  - INST_NOP (32'h00000013).
  - Stage-payload field widths and offsets for ID/EX packing (INST_W=32, ADDR_W=32, RD_W=5), so DW = sum of the fields.
  - SKID mode constants SKID_OFF=0, SKID_ON=1.
- Sub-module pipe_slot: one DW-bit register with a load enable and a sync clear-to-NOP_VAL. Instantiated once for the main slot and once for the skid slot (skid slot only when SKID=1).
- The state/count logic stays in pipe_stage_hs.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid_i=1, in_data_i=32'hDEAD -> out_valid_o=0, out_data_o=NOP_VAL (32'h00000013), in_ready_o=0, count_o=0. First cycle after release: in_ready_o=1.
2. Streaming, both modes, out_ready_i=1: 8 back-to-back entries 1..8 -> out_data_o shows 1..8 on consecutive cycles starting 1 cycle after the first accept, with no gaps.
3. Back-pressure, SKID=1: push A, B while out_ready_i=0 -> count_o=2, in_ready_o=0 on the cycle after B. C is held upstream. Raise out_ready_i -> A, B, C delivered in order, and in_ready_o returns to 1 the cycle after A is consumed.
4. Back-pressure, SKID=0: out_ready_i=0 with one entry held -> in_ready_o=0 combinationally. Raise out_ready_i and in_valid_i together -> same-cycle replace, count_o stays 1.
5. Flush: SKID=1, count_o=2 (A, B), assert flush_i together with in_valid_i (C) -> next cycle out_valid_o=0, out_data_o=NOP_VAL, count_o=0. A, B, C never appear afterwards.
6. Reset mid-operation: count_o=2, assert rst for one cycle -> all entries gone, outputs at reset values. A new entry D after release appears with 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_hs_pkg.sv
// rtl/pipe_stage_hs_pkg.sv - shared constants, payload layout and skid FSM states
package pipe_stage_hs_pkg;

  localparam logic [31:0] INST_NOP = 32'h00000013;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int RD_W   = 5;

  // ID/EX payload packing, LSB first: offset_addr .. inst
  localparam int OFFSET_ADDR_LSB = 0;
  localparam int BASE_ADDR_LSB   = OFFSET_ADDR_LSB + ADDR_W;
  localparam int REG_WEN_LSB     = BASE_ADDR_LSB + ADDR_W;
  localparam int RD_ADDR_LSB     = REG_WEN_LSB + 1;
  localparam int OP2_LSB         = RD_ADDR_LSB + RD_W;
  localparam int OP1_LSB         = OP2_LSB + ADDR_W;
  localparam int INST_ADDR_LSB   = OP1_LSB + ADDR_W;
  localparam int INST_LSB        = INST_ADDR_LSB + ADDR_W;
  localparam int ID_EX_DW        = INST_LSB + INST_W;

  localparam int SKID_OFF = 0;
  localparam int SKID_ON  = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one payload register with load enable and clear-to-NOP
module pipe_slot #(
  parameter int          DW      = 32,
  parameter logic [DW-1:0] NOP_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // Clear wins so reset/flush always leave the bubble value behind.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= NOP_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - valid/ready pipeline stage with flush, bubbles and optional skid slot
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] NOP_VAL = {DW{1'b0}},
  parameter int            SKID    = SKID_OFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    count_o
);

  logic          accept;
  logic          consume;
  logic          main_clr;
  logic          main_load;
  logic [DW-1:0] main_d;

  assign accept  = in_valid_i & in_ready_o;
  assign consume = out_valid_o & out_ready_i;

  pipe_slot #(.DW(DW), .NOP_VAL(NOP_VAL)) u_main (
    .clk  (clk),
    .clr  (main_clr),
    .load (main_load),
    .d    (main_d),
    .q    (out_data_o)
  );

  generate
    if (SKID == SKID_OFF) begin : g_single
      logic valid_q;

      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          valid_q <= 1'b0;
        end else if (accept) begin
          valid_q <= 1'b1;
        end else if (consume) begin
          valid_q <= 1'b0;
        end
      end

      assign in_ready_o  = ~rst & (~valid_q | out_ready_i);
      assign out_valid_o = valid_q;
      assign count_o     = {1'b0, valid_q};
      assign main_clr    = rst | flush_i | (consume & ~accept);
      assign main_load   = accept;
      assign main_d      = in_data_i;
    end else begin : g_skid
      skid_state_e   state_q;
      skid_state_e   state_d;
      logic          ready_q;
      logic          skid_clr;
      logic          skid_load;
      logic [DW-1:0] skid_q;

      pipe_slot #(.DW(DW), .NOP_VAL(NOP_VAL)) u_skid (
        .clk  (clk),
        .clr  (skid_clr),
        .load (skid_load),
        .d    (in_data_i),
        .q    (skid_q)
      );

      // ready_q tracks the next state so in_ready_o never sees out_ready_i.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
        end else begin
          state_q <= state_d;
          ready_q <= (state_d != ST_TWO);
        end
      end

      always_comb begin
        state_d = state_q;
        if (flush_i) begin
          state_d = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
              if (accept && !consume) state_d = ST_TWO;
              else if (!accept && consume) state_d = ST_EMPTY;
            end
            ST_TWO:   if (consume) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
          endcase
        end
      end

      always_comb begin
        main_clr  = rst | flush_i;
        main_load = 1'b0;
        main_d    = in_data_i;
        skid_clr  = rst | flush_i;
        skid_load = 1'b0;
        case (state_q)
          ST_EMPTY: main_load = accept;
          ST_ONE: begin
            if (consume && !accept) main_clr = 1'b1;
            else if (consume && accept) main_load = 1'b1;
            else if (accept) skid_load = 1'b1;
          end
          ST_TWO: begin
            if (consume) begin
              main_load = 1'b1;
              main_d    = skid_q;
              skid_clr  = 1'b1;
            end
          end
          default: begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
          end
        endcase
      end

      assign in_ready_o  = ready_q & ~rst;
      assign out_valid_o = (state_q != ST_EMPTY);
      assign count_o     = state_q;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - bench for pipe_stage_hs in single and skid modes
module tb_pipe_stage_hs;
  import pipe_stage_hs_pkg::*;

  localparam int DW = 32;
  localparam logic [DW-1:0] NOP = INST_NOP;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          ir0, ov0, ir1, ov1;
  logic [DW-1:0] od0, od1;
  logic [1:0]    cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  // Reference: each stage is a FIFO of capacity 1 or 2.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  pipe_stage_hs #(.DW(DW), .NOP_VAL(NOP), .SKID(SKID_OFF)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir0),
    .in_data_i(in_data), .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0),
    .count_o(cnt0)
  );

  pipe_stage_hs #(.DW(DW), .NOP_VAL(NOP), .SKID(SKID_ON)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir1),
    .in_data_i(in_data), .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1),
    .count_o(cnt1)
  );

  typedef struct {
    logic          rst, flush, iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir, e_ov;
    logic [DW-1:0] e_od;
    logic [1:0]    e_cnt;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [DW-1:0] d, logic o,
                              logic eir, logic eov, logic [DW-1:0] eod, logic [1:0] ec);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = o;
    v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic model_ready(int skid, int sz);
    if (rst) return 1'b0;
    if (skid != 0) return sz < 2;
    return (sz == 0) || out_ready;
  endfunction

  task automatic check_model();
    check("m0_ready", ir0, model_ready(0, q0.size()));
    check("m0_valid", ov0, q0.size() > 0);
    check("m0_data",  od0, q0.size() > 0 ? q0[0] : NOP);
    check("m0_count", cnt0, q0.size());
    check("m1_ready", ir1, model_ready(1, q1.size()));
    check("m1_valid", ov1, q1.size() > 0);
    check("m1_data",  od1, q1.size() > 0 ? q1[0] : NOP);
    check("m1_count", cnt1, q1.size());
  endtask

  task automatic model_edge();
    logic a0, a1, c0, c1;
    a0 = in_valid && model_ready(0, q0.size());
    a1 = in_valid && model_ready(1, q1.size());
    c0 = (q0.size() > 0) && out_ready;
    c1 = (q1.size() > 0) && out_ready;
    if (rst || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (c0) void'(q0.pop_front());
      if (a0) q0.push_back(in_data);
      if (c1) void'(q1.pop_front());
      if (a1) q1.push_back(in_data);
    end
  endtask

  task automatic drive(logic r, logic f, logic iv, logic [DW-1:0] d, logic o);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic expect_hs(string tag, int which, logic eir, logic eov,
                           logic [DW-1:0] eod, logic [1:0] ec);
    if (which == 0) begin
      check({tag, "_ready0"}, ir0, eir); check({tag, "_valid0"}, ov0, eov);
      check({tag, "_data0"}, od0, eod);  check({tag, "_count0"}, cnt0, ec);
    end else begin
      check({tag, "_ready1"}, ir1, eir); check({tag, "_valid1"}, ov1, eov);
      check({tag, "_data1"}, od1, eod);  check({tag, "_count1"}, cnt1, ec);
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 1, 32'hDEAD, 0, 0, 0, NOP,   0);
    tbl[1]  = mk(0, 0, 0, 32'h0,    0, 1, 0, NOP,   0);
    tbl[2]  = mk(0, 0, 1, 32'hA,    0, 1, 0, NOP,   0);
    tbl[3]  = mk(0, 0, 1, 32'hB,    0, 1, 1, 32'hA, 1);
    tbl[4]  = mk(0, 0, 1, 32'hC,    0, 0, 1, 32'hA, 2);
    tbl[5]  = mk(0, 0, 1, 32'hC,    1, 0, 1, 32'hA, 2);
    tbl[6]  = mk(0, 0, 1, 32'hC,    1, 1, 1, 32'hB, 1);
    tbl[7]  = mk(0, 0, 0, 32'h0,    1, 1, 1, 32'hC, 1);
    tbl[8]  = mk(0, 0, 0, 32'h0,    0, 1, 0, NOP,   0);
    tbl[9]  = mk(0, 0, 1, 32'h11,   0, 1, 0, NOP,   0);
    tbl[10] = mk(0, 0, 1, 32'h22,   0, 1, 1, 32'h11, 1);
    tbl[11] = mk(0, 1, 1, 32'h33,   0, 0, 1, 32'h11, 2);
    tbl[12] = mk(0, 0, 0, 32'h0,    1, 1, 0, NOP,   0);
    tbl[13] = mk(0, 0, 0, 32'h0,    1, 1, 0, NOP,   0);
    tbl[14] = mk(0, 0, 1, 32'h44,   0, 1, 0, NOP,   0);
    tbl[15] = mk(0, 1, 1, 32'h55,   1, 1, 1, 32'h44, 1);
    tbl[16] = mk(0, 0, 0, 32'h0,    1, 1, 0, NOP,   0);
    tbl[17] = mk(0, 0, 1, 32'h66,   0, 1, 0, NOP,   0);
    tbl[18] = mk(0, 0, 1, 32'h77,   0, 1, 1, 32'h66, 1);
    tbl[19] = mk(1, 0, 1, 32'h88,   1, 0, 1, 32'h66, 2);
    tbl[20] = mk(0, 0, 1, 32'hD,    0, 1, 0, NOP,   0);
    tbl[21] = mk(0, 0, 0, 32'h0,    1, 1, 1, 32'hD, 1);
    tbl[22] = mk(0, 0, 0, 32'h0,    0, 1, 0, NOP,   0);

    drive(1, 0, 1, 32'hDEAD, 0);
    tick();

    // Skid-mode table; the single-register stage rides along against the model.
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      #2;
      expect_hs($sformatf("tbl%0d", i), 1, tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_cnt);
      check_model();
      tick();
    end

    // Back-to-back streaming through both stages.
    for (int i = 0; i < 10; i++) begin
      logic ev;
      drive(0, 0, i < 8, i + 1, 1);
      #2;
      ev = (i >= 1) && (i <= 8);
      expect_hs($sformatf("strm%0d", i), 0, 1'b1, ev, ev ? i : NOP, {1'b0, ev});
      expect_hs($sformatf("strm%0d", i), 1, 1'b1, ev, ev ? i : NOP, {1'b0, ev});
      tick();
    end

    // Single-register back-pressure and same-cycle replace.
    drive(0, 0, 1, 32'h5A, 0); #2; expect_hs("bp0", 0, 1, 0, NOP, 0); tick();
    drive(0, 0, 1, 32'h5B, 0); #2; expect_hs("bp1", 0, 0, 1, 32'h5A, 1);
    out_ready = 1'b1;          #1; expect_hs("bp2", 0, 1, 1, 32'h5A, 1); tick();
    drive(0, 0, 0, 32'h0, 0);  #2; expect_hs("bp3", 0, 0, 1, 32'h5B, 1); tick();
    drive(0, 0, 0, 32'h0, 1);  #2; expect_hs("bp4", 0, 1, 1, 32'h5B, 1); tick();
    drive(0, 0, 0, 32'h0, 0);  #2; expect_hs("bp5", 0, 1, 0, NOP, 0); check_model(); tick();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1);
      #2;
      check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
